// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared BCD display constants and digit-scan helpers
package display_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX_DIGIT = 4'd9;
  localparam int MAX_DIGITS = 8;

  // True when the lowest n digits of value are all 9.
  function automatic logic bcd_all9(input logic [DIGIT_W*MAX_DIGITS-1:0] value, input int n);
    logic res;
    res = 1'b1;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < n && value[DIGIT_W*i +: DIGIT_W] != BCD_MAX_DIGIT) res = 1'b0;
    end
    return res;
  endfunction

  // True when the lowest n digits of value are all 0.
  function automatic logic bcd_all0(input logic [DIGIT_W*MAX_DIGITS-1:0] value, input int n);
    logic res;
    res = 1'b1;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < n && value[DIGIT_W*i +: DIGIT_W] != '0) res = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/bcd_press_counter_if.sv
// rtl/bcd_press_counter_if.sv - pulse requests in, BCD value and strobes out
interface bcd_press_counter_if #(
  parameter int NUM_DIGITS = 4
);
  logic                      inc_pulse;
  logic                      dec_pulse;
  logic                      clr_pulse;
  logic [4*NUM_DIGITS-1:0]   bcd_value;
  logic                      value_upd;
  logic                      wrap_up;
  logic                      wrap_dn;

  modport master (
    output inc_pulse, dec_pulse, clr_pulse,
    input  bcd_value, value_upd, wrap_up, wrap_dn
  );

  modport slave (
    input  inc_pulse, dec_pulse, clr_pulse,
    output bcd_value, value_upd, wrap_up, wrap_dn
  );
endinterface

// File: rtl/bcd_press_counter_digit.sv
// rtl/bcd_press_counter_digit.sv - one BCD digit register with carry/borrow chain
module bcd_digit
  import display_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr_en,
  input  logic               inc_en,
  input  logic               dec_en,
  input  logic               carry_in,
  input  logic               borrow_in,
  output logic [DIGIT_W-1:0] digit,
  output logic               carry_out,
  output logic               borrow_out
);

  logic [DIGIT_W-1:0] digit_q, digit_d;

  // Next digit: clear, or step when every lower digit rolls over.
  always_comb begin
    digit_d = digit_q;
    if (clr_en) begin
      digit_d = '0;
    end else if (inc_en && carry_in) begin
      // >= keeps an illegal digit deterministic by folding it to 0
      digit_d = (digit_q >= BCD_MAX_DIGIT) ? '0 : digit_q + 4'd1;
    end else if (dec_en && borrow_in) begin
      digit_d = (digit_q == '0) ? BCD_MAX_DIGIT : digit_q - 4'd1;
    end
  end

  // Digit storage.
  always_ff @(posedge clk) begin
    if (!rst_n) digit_q <= '0;
    else        digit_q <= digit_d;
  end

  assign digit      = digit_q;
  assign carry_out  = carry_in && (digit_q == BCD_MAX_DIGIT);
  assign borrow_out = borrow_in && (digit_q == '0);

endmodule

// File: rtl/bcd_press_counter.sv
// rtl/bcd_press_counter.sv - BCD up/down press counter with wrap or saturate ends
module bcd_press_counter
  import display_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter bit WRAP_EN    = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bcd_press_counter_if.slave   bus
);

  localparam int VW = DIGIT_W * NUM_DIGITS;

  logic [VW-1:0]                  value;
  logic [DIGIT_W*MAX_DIGITS-1:0]  value_ext;
  logic [NUM_DIGITS:0]            carry;
  logic [NUM_DIGITS:0]            borrow;
  logic at_max, at_min, do_inc, do_dec, clr_req;
  logic upd_q, upd_d, wup_q, wup_d, wdn_q, wdn_d;

  assign carry[0]  = 1'b1;
  assign borrow[0] = 1'b1;

  // Priority decode: clear wins, inc+dec cancel, saturation blocks the step.
  always_comb begin
    value_ext = '0;
    value_ext[VW-1:0] = value;
    at_max  = bcd_all9(value_ext, NUM_DIGITS);
    at_min  = bcd_all0(value_ext, NUM_DIGITS);
    clr_req = bus.clr_pulse;
    do_inc  = !clr_req && bus.inc_pulse && !bus.dec_pulse && (WRAP_EN || !at_max);
    do_dec  = !clr_req && bus.dec_pulse && !bus.inc_pulse && (WRAP_EN || !at_min);
    upd_d   = (clr_req && !at_min) || do_inc || do_dec;
    // a carry out of the top digit is exactly the max->0 wrap
    wup_d   = do_inc && carry[NUM_DIGITS];
    wdn_d   = do_dec && borrow[NUM_DIGITS];
  end

  genvar g;
  generate
    for (g = 0; g < NUM_DIGITS; g++) begin : g_digit
      bcd_digit u_digit (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_en     (clr_req),
        .inc_en     (do_inc),
        .dec_en     (do_dec),
        .carry_in   (carry[g]),
        .borrow_in  (borrow[g]),
        .digit      (value[DIGIT_W*g +: DIGIT_W]),
        .carry_out  (carry[g+1]),
        .borrow_out (borrow[g+1])
      );
    end
  endgenerate

  // One-cycle change and wrap strobes, aligned with the new value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      upd_q <= 1'b0;
      wup_q <= 1'b0;
      wdn_q <= 1'b0;
    end else begin
      upd_q <= upd_d;
      wup_q <= wup_d;
      wdn_q <= wdn_d;
    end
  end

  assign bus.bcd_value = value;
  assign bus.value_upd = upd_q;
  assign bus.wrap_up   = wup_q;
  assign bus.wrap_dn   = wdn_q;

endmodule

// File: tb/tb_bcd_press_counter.sv
// tb/tb_bcd_press_counter.sv - scoreboard bench for wrapping and saturating counters
module tb_bcd_press_counter;

  typedef struct {
    int          cyc;
    logic [15:0] val;
    bit          wu;
    bit          wd;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;
  int   m0 = 0;
  int   m1 = 0;
  exp_t q0[$];
  exp_t q1[$];

  bcd_press_counter_if #(.NUM_DIGITS(4)) if0 ();
  bcd_press_counter_if #(.NUM_DIGITS(4)) if1 ();

  bcd_press_counter #(.NUM_DIGITS(4), .WRAP_EN(1'b1)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .bus(if0)
  );
  bcd_press_counter #(.NUM_DIGITS(4), .WRAP_EN(1'b0)) dut_sat (
    .clk(clk), .rst_n(rst_n), .bus(if1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int d;
    r = '0;
    d = 1;
    for (int k = 0; k < 4; k++) begin
      r[4*k +: 4] = 4'((v / d) % 10);
      d = d * 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference rules on a plain integer count 0..9999.
  task automatic model(inout int m, input bit wrap, input bit i, input bit d, input bit c,
                       inout exp_t q[$]);
    exp_t e;
    bit upd;
    e.cyc = cyc + 1; e.wu = 0; e.wd = 0; upd = 0;
    if (c) begin
      upd = (m != 0); m = 0;
    end else if (i && !d) begin
      if (m == 9999) begin
        if (wrap) begin m = 0; upd = 1; e.wu = 1; end
      end else begin m = m + 1; upd = 1; end
    end else if (d && !i) begin
      if (m == 0) begin
        if (wrap) begin m = 9999; upd = 1; e.wd = 1; end
      end else begin m = m - 1; upd = 1; end
    end
    e.val = to_bcd(m);
    if (upd) q.push_back(e);
  endtask

  task automatic step(input bit i, input bit d, input bit c, input bit r);
    @(negedge clk);
    if0.inc_pulse = i; if0.dec_pulse = d; if0.clr_pulse = c;
    if1.inc_pulse = i; if1.dec_pulse = d; if1.clr_pulse = c;
    rst_n = r;
    if (!r) begin
      m0 = 0; m1 = 0;
    end else begin
      model(m0, 1'b1, i, d, c, q0);
      model(m1, 1'b0, i, d, c, q1);
    end
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
  endtask

  task automatic check_vals(input string name);
    @(negedge clk);
    check({name, "_wrap_val"}, int'(if0.bcd_value), int'(to_bcd(m0)));
    check({name, "_sat_val"},  int'(if1.bcd_value), int'(to_bcd(m1)));
  endtask

  task automatic monitor(input string tag, inout exp_t q[$], input logic [15:0] val,
                         input logic upd, input logic wu, input logic wd);
    exp_t e;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      check({tag, "_missing_upd"}, 0, 1);
    end
    if (upd === 1'b1) begin
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        check({tag, "_value"},   int'(val), int'(e.val));
        check({tag, "_wrap_up"}, int'(wu),  int'(e.wu));
        check({tag, "_wrap_dn"}, int'(wd),  int'(e.wd));
      end else begin
        check({tag, "_spurious_upd"}, 1, 0);
      end
    end else begin
      check({tag, "_idle_strobes"}, int'({upd, wu, wd}), 0);
    end
  endtask

  // Scoreboard monitors, sampled just after each active edge.
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      monitor("wrap", q0, if0.bcd_value, if0.value_upd, if0.wrap_up, if0.wrap_dn);
      monitor("sat",  q1, if1.bcd_value, if1.value_upd, if1.wrap_up, if1.wrap_dn);
    end
  end

  initial begin
    int r;
    bit i, d, c, rs;
    if0.inc_pulse = 0; if0.dec_pulse = 0; if0.clr_pulse = 0;
    if1.inc_pulse = 0; if1.dec_pulse = 0; if1.clr_pulse = 0;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    @(negedge clk);
    check("reset_value", int'(if0.bcd_value), 0);
    check("reset_strobes", int'({if0.value_upd, if0.wrap_up, if0.wrap_dn,
                                 if1.value_upd, if1.wrap_up, if1.wrap_dn}), 0);
    mon_en = 1'b1;
    step(0, 0, 0, 1);

    for (int k = 0; k < 12; k++) begin step(1, 0, 0, 1); step(0, 0, 0, 1); end
    check_vals("twelve");
    check("twelve_abs", int'(if0.bcd_value), 16'h0012);

    do_reset();
    step(0, 1, 0, 1); step(0, 0, 0, 1);
    check_vals("dec_from0");
    check("dec_from0_abs", int'(if0.bcd_value), 16'h9999);
    step(1, 0, 0, 1); step(0, 0, 0, 1);
    check("inc_wrap_abs", int'(if0.bcd_value), 16'h0000);

    do_reset();
    for (int k = 0; k < 9999; k++) step(1, 0, 0, 1);
    step(0, 0, 0, 1);
    check_vals("at_max");
    step(1, 0, 0, 1); step(0, 0, 0, 1);
    check_vals("max_inc");
    check("sat_hold_abs", int'(if1.bcd_value), 16'h9999);

    do_reset();
    for (int k = 0; k < 999; k++) step(1, 0, 0, 1);
    step(1, 0, 0, 1); step(0, 0, 0, 1);
    check_vals("carry3");
    check("carry3_abs", int'(if0.bcd_value), 16'h1000);

    do_reset();
    for (int k = 0; k < 42; k++) step(1, 0, 0, 1);
    step(1, 1, 0, 1); step(0, 0, 0, 1);
    check_vals("incdec");
    step(1, 0, 1, 1); step(0, 0, 0, 1);
    check_vals("clr_inc");
    step(0, 0, 1, 1); step(0, 0, 0, 1);
    check_vals("clr_at0");

    do_reset();
    step(1, 0, 0, 1); step(1, 0, 0, 1); step(1, 0, 0, 0);
    step(1, 0, 0, 1); step(1, 0, 0, 1); step(0, 0, 0, 1);
    check_vals("mid_reset");
    check("mid_reset_abs", int'(if0.bcd_value), 16'h0002);

    for (int k = 0; k < 3000; k++) begin
      r  = $urandom_range(0, 99);
      rs = (r != 0);
      i  = ($urandom_range(0, 2) == 0);
      d  = ($urandom_range(0, 2) == 0);
      c  = ($urandom_range(0, 40) == 0);
      step(i, d, c, rs);
    end
    for (int k = 0; k < 3; k++) step(0, 0, 0, 1);
    check_vals("random_end");
    check("queue0_drained", q0.size(), 0);
    check("queue1_drained", q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
